// File: rtl/present_ctrl_pkg.sv
// Shared definitions for the PRESENT cipher controller: register map, bit indices,
// FSM encoding, word-count helpers and the PRESENT S-box / permutation layers.
package present_ctrl_pkg;

    localparam int CTRL_ADDR   = 0;
    localparam int STATUS_ADDR = 1;
    localparam int KEY_BASE    = 2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CLEAR  = 1;
    localparam int CTRL_ERRCLR = 2;
    localparam int CTRL_IRQEN  = 3;

    localparam int ST_BUSY     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_ERR      = 3;
    localparam int ST_IRQ      = 4;
    localparam int ST_CNT_LSB  = 8;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_LOAD = 2'd1,
        FSM_RUN  = 2'd2,
        FSM_PUSH = 2'd3
    } fsm_state_t;

    function automatic int key_words(input int key_w, input int bus_w);
        return (key_w + bus_w - 1) / bus_w;
    endfunction

    function automatic int blk_words(input int block_w, input int bus_w);
        return (block_w + bus_w - 1) / bus_w;
    endfunction

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 63; i++) begin
            y[(i * 16) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

endpackage

// File: rtl/present_core.sv
// Iterative PRESENT-80/128 encryption core, one round per clock, 31 rounds plus final whitening.
module present_core
    import present_ctrl_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [KEY_W-1:0] key,
    input  logic [63:0]      pt,
    output logic             done,
    output logic [63:0]      ct
);
    logic [63:0]      state_r;
    logic [63:0]      sub_s;
    logic [63:0]      round_s;
    logic [KEY_W-1:0] key_r;
    logic [KEY_W-1:0] key_rot_s;
    logic [KEY_W-1:0] key_next_s;
    logic [4:0]       round_r;
    logic             active_r;
    logic             done_r;

    // Round datapath: add round key, S-box layer, permutation.
    always_comb begin
        sub_s = state_r ^ key_r[KEY_W-1 -: 64];
        for (int n = 0; n < 16; n++) begin
            sub_s[4*n +: 4] = sbox(sub_s[4*n +: 4]);
        end
        round_s = p_layer(sub_s);
    end

    assign key_rot_s = {key_r[KEY_W-62:0], key_r[KEY_W-1:KEY_W-61]};

    generate
        if (KEY_W == 128) begin : g_k128
            // 128-bit key schedule update.
            always_comb begin
                key_next_s          = key_rot_s;
                key_next_s[127:124] = sbox(key_rot_s[127:124]);
                key_next_s[123:120] = sbox(key_rot_s[123:120]);
                key_next_s[66:62]   = key_rot_s[66:62] ^ round_r;
            end
        end else begin : g_k80
            // 80-bit key schedule update.
            always_comb begin
                key_next_s        = key_rot_s;
                key_next_s[79:76] = sbox(key_rot_s[79:76]);
                key_next_s[19:15] = key_rot_s[19:15] ^ round_r;
            end
        end
    endgenerate

    // Round sequencing; done stays high and the result is held until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= 64'd0;
            key_r    <= '0;
            round_r  <= 5'd0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else if (load) begin
            state_r  <= pt;
            key_r    <= key;
            round_r  <= 5'd1;
            active_r <= 1'b1;
            done_r   <= 1'b0;
        end else if (active_r) begin
            state_r <= round_s;
            key_r   <= key_next_s;
            round_r <= round_r + 5'd1;
            if (round_r == 5'd31) begin
                active_r <= 1'b0;
                done_r   <= 1'b1;
            end
        end
    end

    assign done = done_r;
    assign ct   = state_r ^ key_r[KEY_W-1 -: 64];

endmodule

// File: rtl/present_res_fifo.sv
// Show-ahead result FIFO; clear has priority over push and pop on the same cycle.
module present_res_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == FULL_CNT);
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !clear && !empty;
    assign do_push_s = push && !clear && (!full || do_pop_s);

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

endmodule

// File: rtl/present_cipher_fifo_ctrl.sv
// Memory-mapped PRESENT controller: bus decode, start/busy/done FSM, result FIFO.
// Define PRESENT_IRQ_EN to build the interrupt-pending logic; otherwise oIrq stays 0.
module present_cipher_fifo_ctrl
    import present_ctrl_pkg::*;
#(
    parameter int BLOCK_W    = 64,
    parameter int KEY_W      = 80,
    parameter int BUS_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              iReset_n,
    input  logic              iChipselect_n,
    input  logic              iWrite_n,
    input  logic              iRead_n,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [BUS_W-1:0]  idat,
    output logic [BUS_W-1:0]  odat,
    output logic              oIrq
);
    localparam int KEY_WORDS = key_words(KEY_W, BUS_W);
    localparam int BLK_WORDS = blk_words(BLOCK_W, BUS_W);
    localparam int DATA_BASE = KEY_BASE + KEY_WORDS;
    localparam int OUT_BASE  = DATA_BASE + BLK_WORDS;
    localparam int OUT_LAST  = OUT_BASE + BLK_WORDS - 1;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    fsm_state_t       state_r, state_next_s;
    logic [KEY_W-1:0] key_r;
    logic [BLOCK_W-1:0] data_r;
    logic             err_r, irq_en_r, pend_r, irq_r;
    logic [BUS_W-1:0] odat_r;
    logic             wr_s, rd_s, ctrl_wr_s, key_hit_s, data_hit_s, out_hit_s, out_last_s;
    logic             start_req_s, start_ok_s, busy_s, core_load_s;
    logic             fifo_push_s, fifo_pop_s, fifo_clear_s;
    logic             err_next_s, irq_en_next_s, pend_next_s;
    logic             core_done_s, fifo_full_s, fifo_empty_s;
    logic [BLOCK_W-1:0] core_ct_s, fifo_head_s;
    logic [CW-1:0]    fifo_count_s;
    logic [BUS_W-1:0] status_s, rdata_s;
    logic [BUS_W-1:0] out_words_s [BLK_WORDS];

    // Bus strobe decode and command qualification.
    always_comb begin
        wr_s         = !iChipselect_n && !iWrite_n;
        rd_s         = !iChipselect_n && iWrite_n && !iRead_n;
        ctrl_wr_s    = wr_s && (iAddress == ADDR_W'(CTRL_ADDR));
        key_hit_s    = wr_s && (iAddress >= ADDR_W'(KEY_BASE)) && (iAddress < ADDR_W'(DATA_BASE));
        data_hit_s   = wr_s && (iAddress >= ADDR_W'(DATA_BASE)) && (iAddress < ADDR_W'(OUT_BASE));
        out_hit_s    = rd_s && (iAddress >= ADDR_W'(OUT_BASE)) && (iAddress <= ADDR_W'(OUT_LAST));
        out_last_s   = rd_s && (iAddress == ADDR_W'(OUT_LAST));
        start_req_s  = ctrl_wr_s && idat[CTRL_START];
        start_ok_s   = start_req_s && (state_r == FSM_IDLE) && !fifo_full_s;
        fifo_clear_s = ctrl_wr_s && idat[CTRL_CLEAR];
        fifo_pop_s   = out_last_s && !fifo_empty_s;
    end

    // Error, interrupt-enable and interrupt-pending next state; a new error beats a clear.
    always_comb begin
        if (start_req_s && !start_ok_s) begin
            err_next_s = 1'b1;
        end else if ((key_hit_s || data_hit_s) && busy_s) begin
            err_next_s = 1'b1;
        end else if (out_hit_s && fifo_empty_s) begin
            err_next_s = 1'b1;
        end else if (ctrl_wr_s && idat[CTRL_ERRCLR]) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_r;
        end
        irq_en_next_s = ctrl_wr_s ? idat[CTRL_IRQEN] : irq_en_r;
`ifdef PRESENT_IRQ_EN
        if (fifo_clear_s) begin
            pend_next_s = 1'b0;
        end else if (fifo_push_s) begin
            pend_next_s = 1'b1;
        end else if (fifo_pop_s && (fifo_count_s == CW'(1))) begin
            pend_next_s = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
`else
        pend_next_s = 1'b0;
`endif
    end

    // Read data mux: STATUS, or a word of the FIFO head; everything else reads 0.
    always_comb begin
        status_s                      = '0;
        status_s[ST_BUSY]             = busy_s;
        status_s[ST_EMPTY]            = fifo_empty_s;
        status_s[ST_FULL]             = fifo_full_s;
        status_s[ST_ERR]              = err_r;
        status_s[ST_IRQ]              = pend_r;
        status_s[ST_CNT_LSB +: 8]     = 8'(fifo_count_s);
        for (int w = 0; w < BLK_WORDS; w++) begin
            out_words_s[w] = '0;
        end
        for (int b = 0; b < BLOCK_W; b++) begin
            out_words_s[b / BUS_W][b % BUS_W] = fifo_head_s[b];
        end
        rdata_s = '0;
        if (iAddress == ADDR_W'(STATUS_ADDR)) begin
            rdata_s = status_s;
        end else if (out_hit_s && !fifo_empty_s) begin
            for (int w = 0; w < BLK_WORDS; w++) begin
                rdata_s = (iAddress == ADDR_W'(OUT_BASE + w)) ? out_words_s[w] : rdata_s;
            end
        end else begin
            rdata_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!iReset_n) state_r <= FSM_IDLE;
        else           state_r <= state_next_s;
    end

    // FSM next-state logic.
    always_comb begin
        case (state_r)
            FSM_IDLE: state_next_s = start_ok_s ? FSM_LOAD : FSM_IDLE;
            FSM_LOAD: state_next_s = FSM_RUN;
            FSM_RUN:  state_next_s = core_done_s ? FSM_PUSH : FSM_RUN;
            FSM_PUSH: state_next_s = FSM_IDLE;
            default:  state_next_s = FSM_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        case (state_r)
            FSM_IDLE: begin core_load_s = 1'b0; fifo_push_s = 1'b0; busy_s = 1'b0; end
            FSM_LOAD: begin core_load_s = 1'b1; fifo_push_s = 1'b0; busy_s = 1'b1; end
            FSM_RUN:  begin core_load_s = 1'b0; fifo_push_s = 1'b0; busy_s = 1'b1; end
            FSM_PUSH: begin core_load_s = 1'b0; fifo_push_s = 1'b1; busy_s = 1'b1; end
            default:  begin core_load_s = 1'b0; fifo_push_s = 1'b0; busy_s = 1'b0; end
        endcase
    end

    // Key and plaintext registers, bit-wise so unused MSBs of the top word are dropped.
    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            key_r  <= '0;
            data_r <= '0;
        end else if (!busy_s) begin
            for (int b = 0; b < KEY_W; b++) begin
                if (key_hit_s && (iAddress == ADDR_W'(KEY_BASE + b / BUS_W)))
                    key_r[b] <= idat[b % BUS_W];
            end
            for (int b = 0; b < BLOCK_W; b++) begin
                if (data_hit_s && (iAddress == ADDR_W'(DATA_BASE + b / BUS_W)))
                    data_r[b] <= idat[b % BUS_W];
            end
        end
    end

    // Status flags, interrupt output and read-data register.
    always_ff @(posedge clk) begin
        if (!iReset_n) begin
            err_r    <= 1'b0;
            irq_en_r <= 1'b0;
            pend_r   <= 1'b0;
            irq_r    <= 1'b0;
            odat_r   <= '0;
        end else begin
            err_r    <= err_next_s;
            irq_en_r <= irq_en_next_s;
            pend_r   <= pend_next_s;
            irq_r    <= pend_next_s & irq_en_next_s;
            if (rd_s) odat_r <= rdata_s;
        end
    end

    assign odat = odat_r;
    assign oIrq = irq_r;

    present_core #(.KEY_W(KEY_W)) u_core (
        .clk   (clk),
        .rst_n (iReset_n),
        .load  (core_load_s),
        .key   (key_r),
        .pt    (data_r),
        .done  (core_done_s),
        .ct    (core_ct_s)
    );

    present_res_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (iReset_n),
        .clear (fifo_clear_s),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (core_ct_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

endmodule

// File: tb/tb_present_cipher_fifo_ctrl.sv
// Scoreboard bench for present_cipher_fifo_ctrl: reads queue expected data, a monitor compares odat.
module tb_present_cipher_fifo_ctrl;

`ifdef PRESENT_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = 80'hFFFFFFFFFFFFFFFFFFFF;
    localparam logic [63:0] P0 = 64'h0;
    localparam logic [63:0] P1 = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] C00 = 64'h5579C1387B228445;
    localparam logic [63:0] C10 = 64'hE72C46C0F5945049;
    localparam logic [63:0] C01 = 64'hA112FFC72F68417B;
    localparam logic [63:0] C11 = 64'h3333DCD3213210D2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        rd_n = 1'b1;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wdat = 32'd0;
    logic [31:0] odat;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_flag = 1'b0;

    always #5 clk = ~clk;

    present_cipher_fifo_ctrl dut (
        .clk           (clk),
        .iReset_n      (rst_n),
        .iChipselect_n (cs_n),
        .iWrite_n      (wr_n),
        .iRead_n       (rd_n),
        .iAddress      (addr),
        .idat          (wdat),
        .odat          (odat),
        .oIrq          (irq)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a selected read at a rising edge presents odat; compare at the next falling edge.
    always @(posedge clk) rd_flag <= rst_n && !cs_n && wr_n && !rd_n;

    always @(negedge clk) begin
        if (rd_flag) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got 0x%08h with no expectation queued", odat);
            end else begin
                check(name_q.pop_front(), odat, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] stat(input logic b, input logic e, input logic f,
                                         input logic er, input logic [7:0] cnt);
        logic ir;
        ir = IRQ_ON && (cnt != 8'd0);
        return {16'h0, cnt, 3'b000, ir, er, f, e, b};
    endfunction

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; addr = a; wdat = d;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b1; rd_n = 1'b0; addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic load_block(input logic [79:0] k, input logic [63:0] p);
        bus_wr(4'd2, k[31:0]);
        bus_wr(4'd3, k[63:32]);
        bus_wr(4'd4, {16'h0, k[79:64]});
        bus_wr(4'd5, p[31:0]);
        bus_wr(4'd6, p[63:32]);
    endtask

    task automatic start_wait();
        bus_wr(4'd0, 32'h1);
        repeat (45) @(negedge clk);
    endtask

    task automatic pop_check(input logic [63:0] ct, input string nm);
        bus_rd(4'd7, ct[31:0], {nm, "_lo"});
        bus_rd(4'd8, ct[63:32], {nm, "_hi"});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("odat_reset", odat, 32'd0);
        check("irq_reset", {31'd0, irq}, 32'd0);
        bus_rd(4'd1, stat(1'b0, 1'b1, 1'b0, 1'b0, 8'd0), "status_reset");
        bus_rd(4'd9, 32'd0, "unmapped_9");
        bus_rd(4'd15, 32'd0, "unmapped_15");

        // Vector 1 and 2.
        load_block(K0, P0);
        start_wait();
        bus_rd(4'd1, stat(1'b0, 1'b0, 1'b0, 1'b0, 8'd1), "status_v1_done");
        pop_check(C00, "v1");
        bus_rd(4'd1, stat(1'b0, 1'b1, 1'b0, 1'b0, 8'd0), "status_v1_popped");
        load_block(K1, P0);
        start_wait();
        pop_check(C10, "v2");

        // Fill the FIFO, then a refused fifth start.
        load_block(K0, P0); start_wait();
        load_block(K1, P0); start_wait();
        load_block(K0, P1); start_wait();
        load_block(K1, P1); start_wait();
        bus_rd(4'd1, stat(1'b0, 1'b0, 1'b1, 1'b0, 8'd4), "status_full");
        bus_wr(4'd0, 32'h1);
        repeat (5) @(negedge clk);
        bus_rd(4'd1, stat(1'b0, 1'b0, 1'b1, 1'b1, 8'd4), "status_full_err");
        pop_check(C00, "fifo0");
        pop_check(C10, "fifo1");
        pop_check(C01, "fifo2");
        pop_check(C11, "fifo3");
        bus_rd(4'd1, stat(1'b0, 1'b1, 1'b0, 1'b1, 8'd0), "status_drained");
        bus_rd(4'd8, 32'd0, "out_empty");
        bus_wr(4'd0, 32'h4);
        bus_rd(4'd1, stat(1'b0, 1'b1, 1'b0, 1'b0, 8'd0), "status_errclr");

        // Start and key write while busy are both refused.
        load_block(K0, P0);
        bus_wr(4'd0, 32'h1);
        bus_wr(4'd0, 32'h1);
        bus_wr(4'd2, 32'hFFFFFFFF);
        bus_rd(4'd1, stat(1'b1, 1'b1, 1'b0, 1'b1, 8'd0), "status_busy_err");
        repeat (45) @(negedge clk);
        bus_rd(4'd1, stat(1'b0, 1'b0, 1'b0, 1'b1, 8'd1), "status_busy_done");
        pop_check(C00, "busy_ct");
        bus_wr(4'd0, 32'h4);

        // Interrupt enable: follows pending only in the interrupt build.
        bus_wr(4'd0, 32'h8);
        check("irq_enabled_idle", {31'd0, irq}, 32'd0);
        load_block(K1, P1);
        start_wait();
        check("irq_after_done", {31'd0, irq}, {31'd0, IRQ_ON});
        bus_rd(4'd1, stat(1'b0, 1'b0, 1'b0, 1'b0, 8'd1), "status_irq");
        pop_check(C11, "irq_ct");
        check("irq_after_pop", {31'd0, irq}, 32'd0);

        // Reset in the middle of RUN with one entry already queued.
        load_block(K1, P0);
        start_wait();
        bus_wr(4'd0, 32'h1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("odat_midreset", odat, 32'd0);
        check("irq_midreset", {31'd0, irq}, 32'd0);
        bus_rd(4'd1, stat(1'b0, 1'b1, 1'b0, 1'b0, 8'd0), "status_midreset");
        bus_rd(4'd7, 32'd0, "out_after_reset");
        bus_rd(4'd1, stat(1'b0, 1'b1, 1'b0, 1'b1, 8'd0), "status_empty_err");
        bus_wr(4'd0, 32'h4);
        start_wait();
        pop_check(C00, "cleared_regs_ct");

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
